// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: snapshots the value once per frame and
// scans digits over a shared 7-segment bus with a blanking gap between digits.
module seg7_scan_driver #(
    parameter int DIGITS       = 2,
    parameter int REFRESH_DIV  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  value_valid,
    input  logic                  hold,
    input  logic                  lz_blank,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                frame_done_q, frame_done_d;

    logic                cnt_wrap;
    logic [3:0]          nib;
    logic                zero_run;
    logic                blank_lz;

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (cnt_wrap)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        // state_q always describes the phase of the slot position held in cnt_q
        state_d  = (cnt_d < CNT_DRIVE) ? S_BLANK : S_DRIVE;

        snap_d = snap_q;
        if (idx_q == '0 && cnt_q == '0 && value_valid && !hold)
            snap_d = value;
    end

    // Walk digits from the top so zero_run covers nibbles k..DIGITS-1 at digit k
    always_comb begin
        nib      = 4'h0;
        zero_run = 1'b1;
        blank_lz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (snap_q[4*k +: 4] == 4'h0);
            if (idx_q == IW'(k)) begin
                nib      = snap_q[4*k +: 4];
                blank_lz = lz_blank && zero_run && (k != 0);
            end
        end
    end

    always_comb begin
        seg_d        = 7'h00;
        dp_d         = 1'b0;
        dig_en_d     = '0;
        frame_done_d = 1'b0;
        if (state_q == S_DRIVE) begin
            dig_en_d     = DIGITS'(1) << idx_q;
            seg_d        = blank_lz ? 7'h00 : decode(nib);
            dp_d         = hold && (idx_q == '0);
            frame_done_d = cnt_wrap && (idx_q == IDX_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            seg_q        <= 7'h00;
            dp_q         <= 1'b0;
            dig_en_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 2-digit and a 4-digit instance, per-cycle
// expectations queued per frame and popped as the display scans.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 2-digit instance (REFRESH_DIV=8, BLANK=2)
    logic        rst_a = 1'b0;
    logic [7:0]  value_a = 8'h00;
    logic        valid_a = 1'b0, hold_a = 1'b0, lz_a = 1'b0;
    logic [6:0]  seg_a;
    logic        dp_a, fd_a;
    logic [1:0]  en_a;

    // 4-digit instance (REFRESH_DIV=16, BLANK=3)
    logic        rst_b = 1'b0;
    logic [15:0] value_b = 16'h0000;
    logic        valid_b = 1'b0, hold_b = 1'b0, lz_b = 1'b0;
    logic [6:0]  seg_b;
    logic        dp_b, fd_b;
    logic [3:0]  en_b;

    seg7_scan_driver #(.DIGITS(2), .REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .value(value_a), .value_valid(valid_a),
        .hold(hold_a), .lz_blank(lz_a), .seg_out(seg_a), .dp_out(dp_a),
        .dig_en(en_a), .frame_done(fd_a));

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(16), .BLANK_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .value(value_b), .value_valid(valid_b),
        .hold(hold_b), .lz_blank(lz_b), .seg_out(seg_b), .dp_out(dp_b),
        .dig_en(en_b), .frame_done(fd_b));

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One frame of expectations; segs[d] is digit d, dp on digit 0 from slot cycle dp_first
    task automatic push_frame(input int nd, input int div, input int blk,
                              input logic [3:0][6:0] segs, input int dp_first);
        exp_t e;
        for (int d = 0; d < nd; d++) begin
            for (int c = 0; c < div; c++) begin
                e = '0;
                if (c >= blk) begin
                    e.dig = 4'(1 << d);
                    e.seg = segs[d];
                    e.dp  = (d == 0) && (c >= dp_first);
                    e.fd  = (d == nd - 1) && (c == div - 1);
                end
                sbq.push_back(e);
            end
        end
    endtask

    task automatic run(input int n, input bit sel_b);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk($sformatf("sb_nonempty c%0d", cyc), 16'(sbq.size() != 0), 16'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (sel_b) begin
                    chk($sformatf("b_dig c%0d", cyc), 16'(en_b), 16'(e.dig));
                    chk($sformatf("b_seg c%0d", cyc), 16'(seg_b), 16'(e.seg));
                    chk($sformatf("b_dp c%0d", cyc), 16'(dp_b), 16'(e.dp));
                    chk($sformatf("b_fd c%0d", cyc), 16'(fd_b), 16'(e.fd));
                end else begin
                    chk($sformatf("a_dig c%0d", cyc), 16'(en_a), 16'(e.dig));
                    chk($sformatf("a_seg c%0d", cyc), 16'(seg_a), 16'(e.seg));
                    chk($sformatf("a_dp c%0d", cyc), 16'(dp_a), 16'(e.dp));
                    chk($sformatf("a_fd c%0d", cyc), 16'(fd_a), 16'(e.fd));
                end
            end
            cyc++;
        end
    endtask

    // One-hot and inter-digit blank gap, watched on the falling edge
    logic [1:0] last_a = '0;
    int         gap_a  = 0;
    always @(negedge clk) begin
        chk("a_onehot", 16'($countones(en_a) <= 1), 16'd1);
        if (en_a == '0) gap_a++;
        else begin
            if (last_a != '0 && en_a != last_a)
                chk("a_gap", 16'(gap_a >= 2), 16'd1);
            gap_a  = 0;
            last_a = en_a;
        end
    end

    logic [3:0] last_b = '0;
    int         gap_b  = 0;
    always @(negedge clk) begin
        chk("b_onehot", 16'($countones(en_b) <= 1), 16'd1);
        if (en_b == '0) gap_b++;
        else begin
            if (last_b != '0 && en_b != last_b)
                chk("b_gap", 16'(gap_b >= 3), 16'd1);
            gap_b  = 0;
            last_b = en_b;
        end
    end

    localparam int NONE = 99;

    initial begin
        #2 rst_a = 1'b1; rst_b = 1'b1;
        value_a = 8'h3A; valid_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 16'(seg_a), 16'h0);
        chk("rst_dig", 16'(en_a), 16'h0);
        chk("rst_dp", 16'(dp_a), 16'h0);
        chk("rst_fd", 16'(fd_a), 16'h0);
        rst_a = 1'b0;

        // Basic scan, then a value change mid-frame must not tear the display
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h4F, 7'h77}, NONE);
        run(9, 0);
        value_a = 8'hC5;
        run(7, 0);
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h39, 7'h6D}, NONE);
        run(16, 0);

        // Not valid at the boundary: old snapshot retained
        valid_a = 1'b0; value_a = 8'h12;
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h39, 7'h6D}, NONE);
        run(16, 0);

        // Leading-zero blanking
        valid_a = 1'b1; value_a = 8'h05; lz_a = 1'b1;
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h00, 7'h6D}, NONE);
        run(16, 0);
        value_a = 8'h00;
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h00, 7'h3F}, NONE);
        run(16, 0);
        lz_a = 1'b0;
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h3F, 7'h3F}, NONE);
        run(16, 0);

        // Hold freezes the snapshot and lights the decimal point on digit 0
        value_a = 8'h3A;
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h4F, 7'h77}, NONE);
        run(16, 0);
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h4F, 7'h77}, 4);
        run(4, 0);
        hold_a = 1'b1; value_a = 8'h77;
        run(12, 0);
        for (int f = 0; f < 3; f++) begin
            push_frame(2, 8, 2, {7'h0, 7'h0, 7'h4F, 7'h77}, 2);
            run(16, 0);
        end
        hold_a = 1'b0;
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h07, 7'h07}, NONE);
        run(16, 0);

        // Async reset in digit 1 DRIVE aborts the frame
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h07, 7'h07}, NONE);
        run(13, 0);
        value_a = 8'hE1;
        rst_a = 1'b1;
        #1;
        chk("async_seg", 16'(seg_a), 16'h0);
        chk("async_dig", 16'(en_a), 16'h0);
        chk("async_dp", 16'(dp_a), 16'h0);
        chk("async_fd", 16'(fd_a), 16'h0);
        #2 rst_a = 1'b0;
        sbq.delete();
        push_frame(2, 8, 2, {7'h0, 7'h0, 7'h79, 7'h06}, NONE);
        run(16, 0);

        // 4-digit instance
        value_b = 16'h1A2F; valid_b = 1'b1;
        rst_b = 1'b0;
        push_frame(4, 16, 3, {7'h06, 7'h77, 7'h5B, 7'h71}, NONE);
        run(64, 1);
        push_frame(4, 16, 3, {7'h06, 7'h77, 7'h5B, 7'h71}, NONE);
        run(25, 1);
        value_b = 16'h0050; lz_b = 1'b1;
        rst_b = 1'b1;
        #1;
        chk("b_async_seg", 16'(seg_b), 16'h0);
        chk("b_async_dig", 16'(en_b), 16'h0);
        #2 rst_b = 1'b0;
        sbq.delete();
        push_frame(4, 16, 3, {7'h00, 7'h00, 7'h6D, 7'h3F}, NONE);
        run(64, 1);
        value_b = 16'h3005;
        push_frame(4, 16, 3, {7'h4F, 7'h3F, 7'h3F, 7'h6D}, NONE);
        run(64, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
